// File: rtl/debug_avalon_ctrl_if.sv
// debug_avalon_ctrl_if: host-side Avalon-MM register port of the debug controller
interface debug_avalon_ctrl_if;
    logic [2:0]  avs_address;
    logic        avs_chipselect;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    modport master (
        output avs_address, avs_chipselect, avs_read, avs_write, avs_writedata,
        input  avs_readdata, avs_waitrequest
    );
    modport slave (
        input  avs_address, avs_chipselect, avs_read, avs_write, avs_writedata,
        output avs_readdata, avs_waitrequest
    );
endinterface

// File: rtl/debug_avalon_ctrl.sv
// debug_avalon_ctrl: turns host register accesses into one-shot debug transactions on the memory interconnect
module debug_avalon_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                reset_n,
    debug_avalon_ctrl_if.slave  avs,
    output logic [2:0]          mode,
    output logic [31:0]         debugAddress,
    output logic [31:0]         DEBUGWrite,
    output logic                chipselect_debug,
    input  logic [31:0]         dataReadDebug,
    input  logic                doneExt,
    input  logic                doneInstr
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    typedef enum logic [2:0] {S_IDLE, S_ARM, S_ISSUE, S_WAIT, S_CAPTURE} state_t;
    state_t state;
    logic [2:0] cmd, code;
    logic [31:0] rdata, rd_mux, status;
    logic done_f, timeout_f, overrun_f, illegal_f;
    logic [CW-1:0] cnt;
    logic wr, rd, busy, legal, start, sel_done, is_pc, is_read, counting, expire, set_done, set_ov, set_il;
    logic [3:0] clr;
    assign avs.avs_waitrequest = 1'b0;
    always_comb begin
        wr       = avs.avs_chipselect && avs.avs_write;
        rd       = avs.avs_chipselect && avs.avs_read;
        code     = avs.avs_writedata[2:0];
        busy     = state != S_IDLE;
        legal    = code != 3'd0 && code != 3'd7;
        start    = wr && avs.avs_address == 3'd0 && !busy && legal;
        sel_done = (cmd == 3'd1 || cmd == 3'd3) ? doneExt : doneInstr;
        is_pc    = cmd == 3'd5 || cmd == 3'd6;
        is_read  = is_pc || cmd == 3'd1 || cmd == 3'd2;
        counting = state == S_ARM || state == S_WAIT;
        expire   = counting && cnt == CW'(TIMEOUT_CYCLES - 1);
        set_done = state == S_CAPTURE;
        set_ov   = wr && busy && avs.avs_address <= 3'd2;
        set_il   = wr && avs.avs_address == 3'd0 && !busy && !legal;
        clr      = (wr && avs.avs_address == 3'd4) ? avs.avs_writedata[4:1] : 4'd0;
        status   = {27'd0, illegal_f, overrun_f, timeout_f, done_f, busy};
        rd_mux   = avs.avs_address == 3'd0 ? {29'd0, cmd} :
                   avs.avs_address == 3'd1 ? debugAddress :
                   avs.avs_address == 3'd2 ? DEBUGWrite :
                   avs.avs_address == 3'd3 ? rdata :
                   avs.avs_address == 3'd4 ? status : 32'd0;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            cmd              <= 3'd0;
            mode             <= 3'd0;
            chipselect_debug <= 1'b0;
            debugAddress     <= 32'd0;
            DEBUGWrite       <= 32'd0;
            rdata            <= 32'd0;
            avs.avs_readdata <= 32'd0;
            done_f           <= 1'b0;
            timeout_f        <= 1'b0;
            overrun_f        <= 1'b0;
            illegal_f        <= 1'b0;
            cnt              <= '0;
        end else begin
            avs.avs_readdata <= rd ? rd_mux : 32'd0;
            if (wr && !busy && avs.avs_address == 3'd1) debugAddress <= avs.avs_writedata;
            if (wr && !busy && avs.avs_address == 3'd2) DEBUGWrite <= avs.avs_writedata;
            // hardware sets override a same-cycle host clear
            done_f    <= (done_f && !clr[0] && !start) || set_done;
            timeout_f <= (timeout_f && !clr[1] && !start) || expire;
            overrun_f <= (overrun_f && !clr[2]) || set_ov;
            illegal_f <= (illegal_f && !clr[3]) || set_il;
            cnt <= start ? '0 : counting ? cnt + CW'(1) : cnt;
            chipselect_debug <= state == S_ARM && !expire && !is_pc && !sel_done;
            if (expire) begin
                state <= S_IDLE;
                mode  <= 3'd0;
            end else begin
                case (state)
                    S_IDLE: if (start) begin
                        state <= S_ARM;
                        cmd   <= code;
                        mode  <= code;
                    end
                    S_ARM: state <= is_pc ? S_CAPTURE : !sel_done ? S_ISSUE : S_ARM;
                    S_ISSUE: state <= S_WAIT;
                    S_WAIT: state <= sel_done ? S_CAPTURE : S_WAIT;
                    S_CAPTURE: begin
                        state <= S_IDLE;
                        mode  <= 3'd0;
                        if (is_read) rdata <= dataReadDebug;
                    end
                    default: begin
                        state <= S_IDLE;
                        mode  <= 3'd0;
                    end
                endcase
            end
        end
    end
endmodule
